// File: rtl/seq_gen_serial_pkg.sv
// Shared definitions for the serial pattern transmitter: FSM state codes
// and the default "101" pattern used to drive sequence detectors.
package seq_gen_serial_pkg;

   // S_UNUSED is never entered; the FSM decodes it back to IDLE.
   typedef enum logic [1:0] {
      S_IDLE   = 2'b00,
      S_SHIFT  = 2'b01,
      S_GAP    = 2'b10,
      S_UNUSED = 2'b11
   } state_t;

   localparam logic [2:0] PAT_101 = 3'b101;

endpackage

// File: rtl/seq_gen_serial_piso_shift.sv
// Parallel-in serial-out shift register, MSB first.
// Priority: synchronous clear, then parallel load, then shift left.
module piso_shift
   import seq_gen_serial_pkg::*;
#(
   parameter int DATA_W = 3
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              load,
   input  logic              shift,
   input  logic [DATA_W-1:0] din,
   output logic              msb
);

   logic [DATA_W-1:0] shreg;

   // Shift register: clear, load a new word, or move the next bit into the MSB.
   // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (clr) begin
         shreg <= '0;
      end else if (load) begin
         shreg <= din;
      end else if (shift) begin
         shreg <= shreg << 1;
      end
   end

   assign msb = shreg[DATA_W-1];

endmodule

// File: rtl/seq_gen_serial.sv
// Serial pattern transmitter. Accepts a pattern, repeat count and gap over a
// valid/ready port, then emits the pattern MSB-first one bit per clock, with
// optional zero-bit gaps between repeats and a done pulse at the end.
module seq_gen_serial
   import seq_gen_serial_pkg::*;
#(
   parameter int DATA_W = 3,
   parameter int CNT_W  = 4,
   parameter int GAP_W  = 4
) (
   input  logic              clk,
   input  logic              arst,
   input  logic              load_valid,
   output logic              load_ready,
   input  logic [DATA_W-1:0] load_data,
   input  logic [CNT_W-1:0]  load_rep,
   input  logic [GAP_W-1:0]  load_gap,
   input  logic              abort,
   output logic              out,
   output logic              out_valid,
   output logic              busy,
   output logic              done
);

   localparam int BIT_W = $clog2(DATA_W) + 1;
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

   state_t            state, state_next;
   logic [DATA_W-1:0] pattern;
   logic [BIT_W-1:0]  bit_cnt;
   logic [CNT_W-1:0]  rep_left;
   logic [GAP_W-1:0]  gap_len;
   logic [GAP_W-1:0]  gap_cnt;
   logic              shreg_msb;

   // FSM control strobes
   logic accept;     // new load captured from IDLE
   logic reload;     // restart the pattern for the next repeat
   logic bit_dec;    // advance one bit within the current repeat
   logic rep_dec;    // one repeat consumed
   logic gap_start;  // enter GAP with gap_len-1 remaining
   logic gap_dec;    // one gap bit consumed
   logic done_next;

   piso_shift #(.DATA_W(DATA_W)) u_piso (
      .clk   (clk),
      .clr   (arst),
      .load  (accept | reload),
      .shift (bit_dec),
      .din   (accept ? load_data : pattern),
      .msb   (shreg_msb)
   );

   // Next-state and control decode for IDLE/SHIFT/GAP.
   // NOTE: every signal gets a default first so no path through the case leaves one unassigned (no latches).
   always_comb begin
      state_next = state;
      accept     = 1'b0;
      reload     = 1'b0;
      bit_dec    = 1'b0;
      rep_dec    = 1'b0;
      gap_start  = 1'b0;
      gap_dec    = 1'b0;
      done_next  = 1'b0;
      case (state)
         S_IDLE: begin
            if (load_valid) begin
               accept     = 1'b1;
               state_next = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (abort) begin
               state_next = S_IDLE;
            end else if (bit_cnt == '0) begin
               if (rep_left == '0) begin
                  state_next = S_IDLE;
                  done_next  = 1'b1;
               end else if (gap_len == '0) begin
                  reload  = 1'b1;
                  rep_dec = 1'b1;
               end else begin
                  gap_start  = 1'b1;
                  rep_dec    = 1'b1;
                  state_next = S_GAP;
               end
            end else begin
               bit_dec = 1'b1;
            end
         end
         S_GAP: begin
            if (abort) begin
               state_next = S_IDLE;
            end else if (gap_cnt == '0) begin
               reload     = 1'b1;
               state_next = S_SHIFT;
            end else begin
               gap_dec = 1'b1;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   // State register; reset takes priority over any transition.
   always_ff @(posedge clk) begin
      if (arst) state <= S_IDLE;
      else      state <= state_next;
   end

   // Pattern latch, repeat/gap counters and done pulse.
   always_ff @(posedge clk) begin
      if (arst) begin
         pattern  <= '0;
         bit_cnt  <= '0;
         rep_left <= '0;
         gap_len  <= '0;
         gap_cnt  <= '0;
         done     <= 1'b0;
      end else begin
         done <= done_next;
         if (accept) begin
            pattern  <= load_data;
            rep_left <= load_rep;
            gap_len  <= load_gap;
            bit_cnt  <= BIT_LAST;
         end
         if (reload)    bit_cnt  <= BIT_LAST;
         if (bit_dec)   bit_cnt  <= bit_cnt - BIT_W'(1);
         if (rep_dec)   rep_left <= rep_left - CNT_W'(1);
         if (gap_start) gap_cnt  <= gap_len - GAP_W'(1);
         if (gap_dec)   gap_cnt  <= gap_cnt - GAP_W'(1);
      end
   end

   // Stream outputs decode from registers only; load_ready is also held low during reset.
   assign out        = (state == S_SHIFT) ? shreg_msb : 1'b0;
   assign out_valid  = (state == S_SHIFT) || (state == S_GAP);
   assign busy       = out_valid;
   assign load_ready = (state == S_IDLE) && !arst;

endmodule

// File: tb/tb_seq_gen_serial.sv
// Testbench for seq_gen_serial: directed scenarios plus randomized loads,
// checked against a bit-stream model built from pattern/repeat/gap rules.
module tb_seq_gen_serial;
   import seq_gen_serial_pkg::*;

   localparam int DATA_W = 3;
   localparam int CNT_W  = 4;
   localparam int GAP_W  = 4;

   logic              clk = 1'b0;
   logic              arst, load_valid, load_ready, abort;
   logic              out, out_valid, busy, done;
   logic [DATA_W-1:0] load_data;
   logic [CNT_W-1:0]  load_rep;
   logic [GAP_W-1:0]  load_gap;

   int compared   = 0;
   int mismatched = 0;
   bit exp_q[$];

   always #5 clk = ~clk;

   seq_gen_serial #(.DATA_W(DATA_W), .CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
      .clk        (clk),
      .arst       (arst),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_data  (load_data),
      .load_rep   (load_rep),
      .load_gap   (load_gap),
      .abort      (abort),
      .out        (out),
      .out_valid  (out_valid),
      .busy       (busy),
      .done       (done)
   );

   // Expected stream: (rep+1) copies of the pattern MSB-first, gap zeros between copies.
   function automatic void model(input logic [DATA_W-1:0] pat, input int rep, input int gap);
      exp_q.delete();
      for (int r = 0; r <= rep; r++) begin
         for (int b = DATA_W - 1; b >= 0; b--) exp_q.push_back(pat[b]);
         if (r < rep) for (int g = 0; g < gap; g++) exp_q.push_back(1'b0);
      end
   endfunction

   // Called at a negedge in IDLE; returns at the negedge of the first stream cycle.
   task automatic start_load(input logic [DATA_W-1:0] pat, input logic [CNT_W-1:0] rep,
                             input logic [GAP_W-1:0] gap, input logic keep);
      load_valid = 1'b1;
      load_data  = pat;
      load_rep   = rep;
      load_gap   = gap;
      @(negedge clk);
      load_valid = keep;
      load_data  = DATA_W'($urandom);
      load_rep   = CNT_W'($urandom);
      load_gap   = GAP_W'($urandom);
   endtask

   task automatic test_reset;
      arst = 1'b1; abort = 1'b0;
      load_valid = 1'b1; load_data = PAT_101; load_rep = '0; load_gap = '0;
      repeat (2) @(negedge clk);
      compared++;
      if ({load_ready, busy, out_valid, out, done} !== 5'b00000) begin
         mismatched++;
         $display("FAIL reset_hold: rdy/busy/ov/out/done=%b expected 00000",
                  {load_ready, busy, out_valid, out, done});
      end
      arst = 1'b0; load_valid = 1'b0;
      @(negedge clk);
      compared++;
      if ({load_ready, busy, out_valid, done} !== 4'b1000) begin
         mismatched++;
         $display("FAIL reset_release: rdy/busy/ov/done=%b expected 1000",
                  {load_ready, busy, out_valid, done});
      end
   endtask

   task automatic test_single;
      model(PAT_101, 0, 0);
      start_load(PAT_101, '0, '0, 1'b0);
      foreach (exp_q[i]) begin
         compared++;
         if ({out_valid, out, done, busy} !== {1'b1, exp_q[i], 1'b0, 1'b1}) begin
            mismatched++;
            $display("FAIL single_bit%0d: ov/out/done/busy=%b expected %b", i,
                     {out_valid, out, done, busy}, {1'b1, exp_q[i], 1'b0, 1'b1});
         end
         @(negedge clk);
      end
      compared++;
      if ({out_valid, done, load_ready, busy} !== 4'b0110) begin
         mismatched++;
         $display("FAIL single_done: ov/done/rdy/busy=%b expected 0110",
                  {out_valid, done, load_ready, busy});
      end
      @(negedge clk);
      compared++;
      if (done !== 1'b0) begin
         mismatched++;
         $display("FAIL single_done_pulse: done=%b expected 0", done);
      end
   endtask

   task automatic test_overlap;
      logic [2:0] win = '0;
      int hits = 0;
      model(PAT_101, 1, 0);
      start_load(PAT_101, CNT_W'(1), '0, 1'b0);
      foreach (exp_q[i]) begin
         compared++;
         if ({out_valid, out, done} !== {1'b1, exp_q[i], 1'b0}) begin
            mismatched++;
            $display("FAIL overlap_bit%0d: ov/out/done=%b expected %b", i,
                     {out_valid, out, done}, {1'b1, exp_q[i], 1'b0});
         end
         win = {win[1:0], out};
         if (i >= 2 && win == 3'b101) hits++;
         @(negedge clk);
      end
      compared++;
      if ({out_valid, done} !== 2'b01) begin
         mismatched++;
         $display("FAIL overlap_done: ov/done=%b expected 01", {out_valid, done});
      end
      compared++;
      if (hits !== 2) begin
         mismatched++;
         $display("FAIL overlap_hits: got %0d expected 2", hits);
      end
   endtask

   task automatic test_gap;
      model(PAT_101, 1, 2);
      start_load(PAT_101, CNT_W'(1), GAP_W'(2), 1'b0);
      foreach (exp_q[i]) begin
         compared++;
         if ({out_valid, out, done} !== {1'b1, exp_q[i], 1'b0}) begin
            mismatched++;
            $display("FAIL gap_bit%0d: ov/out/done=%b expected %b", i,
                     {out_valid, out, done}, {1'b1, exp_q[i], 1'b0});
         end
         @(negedge clk);
      end
      compared++;
      if ({out_valid, done, load_ready} !== 3'b011) begin
         mismatched++;
         $display("FAIL gap_done: ov/done/rdy=%b expected 011", {out_valid, done, load_ready});
      end
      @(negedge clk);
   endtask

   task automatic test_abort;
      start_load(PAT_101, CNT_W'(3), '0, 1'b0);
      compared++;
      if ({out_valid, out} !== 2'b11) begin
         mismatched++;
         $display("FAIL abort_bit0: ov/out=%b expected 11", {out_valid, out});
      end
      @(negedge clk);
      compared++;
      if ({out_valid, out} !== 2'b10) begin
         mismatched++;
         $display("FAIL abort_bit1: ov/out=%b expected 10", {out_valid, out});
      end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      compared++;
      if ({out_valid, out, busy, done, load_ready} !== 5'b00001) begin
         mismatched++;
         $display("FAIL abort_stop: ov/out/busy/done/rdy=%b expected 00001",
                  {out_valid, out, busy, done, load_ready});
      end
      repeat (3) @(negedge clk);
      compared++;
      if ({done, busy} !== 2'b00) begin
         mismatched++;
         $display("FAIL abort_quiet: done/busy=%b expected 00", {done, busy});
      end
      // abort in IDLE together with a load: the load still goes through
      model(3'b110, 0, 0);
      abort = 1'b1; load_valid = 1'b1; load_data = 3'b110; load_rep = '0; load_gap = '0;
      @(negedge clk);
      abort = 1'b0; load_valid = 1'b0;
      foreach (exp_q[i]) begin
         compared++;
         if ({out_valid, out, busy} !== {1'b1, exp_q[i], 1'b1}) begin
            mismatched++;
            $display("FAIL abort_idle_bit%0d: ov/out/busy=%b expected %b", i,
                     {out_valid, out, busy}, {1'b1, exp_q[i], 1'b1});
         end
         @(negedge clk);
      end
      compared++;
      if (done !== 1'b1) begin
         mismatched++;
         $display("FAIL abort_idle_done: done=%b expected 1", done);
      end
      @(negedge clk);
   endtask

   task automatic test_abort_final;
      model(PAT_101, 0, 0);
      start_load(PAT_101, '0, '0, 1'b0);
      for (int i = 0; i < DATA_W; i++) begin
         compared++;
         if ({out_valid, out} !== {1'b1, exp_q[i]}) begin
            mismatched++;
            $display("FAIL abort_final_bit%0d: ov/out=%b expected %b", i,
                     {out_valid, out}, {1'b1, exp_q[i]});
         end
         if (i == DATA_W - 1) abort = 1'b1;
         @(negedge clk);
      end
      abort = 1'b0;
      compared++;
      if ({out_valid, done, busy, load_ready} !== 4'b0001) begin
         mismatched++;
         $display("FAIL abort_final: ov/done/busy/rdy=%b expected 0001",
                  {out_valid, done, busy, load_ready});
      end
   endtask

   task automatic test_reset_mid_gap;
      model(PAT_101, 2, 3);
      start_load(PAT_101, CNT_W'(2), GAP_W'(3), 1'b0);
      for (int i = 0; i <= DATA_W; i++) begin
         compared++;
         if ({out_valid, out, busy} !== {1'b1, exp_q[i], 1'b1}) begin
            mismatched++;
            $display("FAIL rst_gap_bit%0d: ov/out/busy=%b expected %b", i,
                     {out_valid, out, busy}, {1'b1, exp_q[i], 1'b1});
         end
         if (i < DATA_W) @(negedge clk);
      end
      arst = 1'b1; load_valid = 1'b1; load_data = 3'b111;
      repeat (2) begin
         @(negedge clk);
         compared++;
         if ({out, out_valid, busy, done, load_ready} !== 5'b00000) begin
            mismatched++;
            $display("FAIL rst_gap_hold: out/ov/busy/done/rdy=%b expected 00000",
                     {out, out_valid, busy, done, load_ready});
         end
      end
      arst = 1'b0; load_valid = 1'b0;
      @(negedge clk);
      compared++;
      if ({busy, out_valid, done, load_ready} !== 4'b0001) begin
         mismatched++;
         $display("FAIL rst_gap_release: busy/ov/done/rdy=%b expected 0001",
                  {busy, out_valid, done, load_ready});
      end
   endtask

   task automatic test_back_to_back;
      model(PAT_101, 0, 0);
      start_load(PAT_101, '0, '0, 1'b1);
      foreach (exp_q[i]) begin
         compared++;
         if ({out_valid, out, load_ready} !== {1'b1, exp_q[i], 1'b0}) begin
            mismatched++;
            $display("FAIL b2b_first_bit%0d: ov/out/rdy=%b expected %b", i,
                     {out_valid, out, load_ready}, {1'b1, exp_q[i], 1'b0});
         end
         @(negedge clk);
      end
      compared++;
      if ({out_valid, done, load_ready} !== 3'b011) begin
         mismatched++;
         $display("FAIL b2b_bubble: ov/done/rdy=%b expected 011", {out_valid, done, load_ready});
      end
      load_data = 3'b110; load_rep = '0; load_gap = '0;
      @(negedge clk);
      load_valid = 1'b0;
      model(3'b110, 0, 0);
      foreach (exp_q[i]) begin
         compared++;
         if ({out_valid, out, done} !== {1'b1, exp_q[i], 1'b0}) begin
            mismatched++;
            $display("FAIL b2b_second_bit%0d: ov/out/done=%b expected %b", i,
                     {out_valid, out, done}, {1'b1, exp_q[i], 1'b0});
         end
         @(negedge clk);
      end
      compared++;
      if ({out_valid, done} !== 2'b01) begin
         mismatched++;
         $display("FAIL b2b_done: ov/done=%b expected 01", {out_valid, done});
      end
      @(negedge clk);
   endtask

   task automatic test_random;
      for (int n = 0; n < 25; n++) begin
         logic [DATA_W-1:0] pat = DATA_W'($urandom);
         int rep  = $urandom_range(0, 3);
         int gap  = $urandom_range(0, 3);
         logic keep = 1'($urandom_range(0, 1));
         repeat ($urandom_range(0, 2)) @(negedge clk);
         model(pat, rep, gap);
         compared++;
         if (load_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL rand%0d_ready: rdy=%b expected 1", n, load_ready);
         end
         start_load(pat, CNT_W'(rep), GAP_W'(gap), keep);
         foreach (exp_q[i]) begin
            compared++;
            if ({out_valid, out, done, busy} !== {1'b1, exp_q[i], 1'b0, 1'b1}) begin
               mismatched++;
               $display("FAIL rand%0d_bit%0d: ov/out/done/busy=%b expected %b", n, i,
                        {out_valid, out, done, busy}, {1'b1, exp_q[i], 1'b0, 1'b1});
            end
            @(negedge clk);
         end
         compared++;
         if ({out_valid, done, load_ready} !== 3'b011) begin
            mismatched++;
            $display("FAIL rand%0d_done: ov/done/rdy=%b expected 011", n,
                     {out_valid, done, load_ready});
         end
         load_valid = 1'b0;
         @(negedge clk);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_single();
      test_overlap();
      test_gap();
      test_abort();
      test_abort_final();
      test_reset_mid_gap();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
